// File: rtl/jam_cost_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_arbiter
// Purpose  : Shares one worker/job cost table (1-cycle read latency) between
//            two permutation-search engines. Round-robin arbitration with
//            locked bursts keeps one engine's lookups for a permutation
//            contiguous. Each returned cost is routed back to the engine that
//            issued the lookup.
// Ports    : CLK, RST        clock, asynchronous active-high reset
//            reqN/lockN      engine N lookup request / more beats follow
//            wN/jN           engine N worker / job index
//            gntN            engine N lookup issued this cycle (combinational)
//            rvalidN/rdataN  cost for engine N's previous-cycle lookup
//            W/J, Cost       cost table address out, data in (1 cycle later)
//            busy_cnt        saturating count of cycles with a denied request
// Revision : 1.0  initial release
// ============================================================================
module jam_cost_arbiter #(
  parameter int IDX_W     = 3,
  parameter int COST_W    = 7,
  parameter int BURST_MAX = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              lock0,
  input  logic [IDX_W-1:0]  w0,
  input  logic [IDX_W-1:0]  j0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [COST_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [IDX_W-1:0]  w1,
  input  logic [IDX_W-1:0]  j1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [COST_W-1:0] rdata1,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [15:0]       busy_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic [1:0]  state_q,    state_d;
  logic        rr_ptr_q,   rr_ptr_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  tag_q,      tag_d;
  logic [15:0] busy_q,     busy_d;

  logic gnt0_raw;
  logic gnt1_raw;
  logic denied;

  // Next-state / grant decision. Grants are computed ungated here and forced
  // low below while RST is asserted.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt0_raw   = 1'b0;
    gnt1_raw   = 1'b0;

    case (state_q)
      IDLE: begin
        // Contention resolved by rr_ptr; a lone requester always wins.
        if (req0 && (!req1 || !rr_ptr_q)) begin
          gnt0_raw = 1'b1;
        end else if (req1) begin
          gnt1_raw = 1'b1;
        end

        if (gnt0_raw) begin
          // The first beat of a burst counts toward the limit, so a limit of
          // one with the other engine waiting degenerates to a single beat.
          if (lock0 && !(req1 && (BURST_LIM <= 4'd1))) begin
            state_d    = OWN0;
            beat_cnt_d = 4'd1;
          end else begin
            rr_ptr_d = 1'b1;
          end
        end else if (gnt1_raw) begin
          if (lock1 && !(req0 && (BURST_LIM <= 4'd1))) begin
            state_d    = OWN1;
            beat_cnt_d = 4'd1;
          end else begin
            rr_ptr_d = 1'b0;
          end
        end
      end

      OWN0: begin
        // A dropped req0 is a bubble; ownership is kept while lock0 holds.
        gnt0_raw = req0;
        if (req0 && (beat_cnt_q < BURST_LIM)) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
        if (!lock0 || ((beat_cnt_d >= BURST_LIM) && req1)) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b1;
        end
      end

      OWN1: begin
        gnt1_raw = req1;
        if (req1 && (beat_cnt_q < BURST_LIM)) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
        if (!lock1 || ((beat_cnt_d >= BURST_LIM) && req0)) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt0 = gnt0_raw & ~RST;
  assign gnt1 = gnt1_raw & ~RST;

  assign W = gnt1 ? w1 : (gnt0 ? w0 : '0);
  assign J = gnt1 ? j1 : (gnt0 ? j0 : '0);

  // The tag remembers who issued last cycle's lookup so the table data can
  // be steered to the right engine when it arrives.
  assign tag_d = {gnt1, gnt0};

  assign denied = (req0 & ~gnt0) | (req1 & ~gnt1);
  assign busy_d = (denied && (busy_q != 16'hFFFF)) ? busy_q + 16'd1 : busy_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= 4'd0;
      tag_q      <= 2'b00;
      busy_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
    end
  end

  assign rvalid0  = tag_q[0];
  assign rvalid1  = tag_q[1];
  assign rdata0   = tag_q[0] ? Cost : '0;
  assign rdata1   = tag_q[1] ? Cost : '0;
  assign busy_cnt = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_cost_arbiter
// Purpose  : Directed self-checking bench for jam_cost_arbiter with a
//            1-cycle-latency cost table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jam_cost_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, lock0, req1, lock1;
  logic [2:0] w0, j0, w1, j1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [6:0] rdata0, rdata1, cost;
  logic [2:0] W, J;
  logic [15:0] busy_cnt;

  int n_tests;
  int n_fail;

  jam_cost_arbiter #(.IDX_W(3), .COST_W(7), .BURST_MAX(8)) dut (
    .CLK(clk), .RST(rst),
    .req0(req0), .lock0(lock0), .w0(w0), .j0(j0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .w1(w1), .j1(j1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .W(W), .J(J), .Cost(cost), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cost table: entry = (13*w + 7*j + 1) mod 128, except [3][5] = 42.
  function automatic logic [6:0] tbl(input logic [2:0] a, input logic [2:0] b);
    int v;
    if (a == 3'd3 && b == 3'd5) return 7'd42;
    v = (13 * int'(a) + 7 * int'(b) + 1) % 128;
    return 7'(v);
  endfunction

  always @(posedge clk) cost <= tbl(W, J);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs right after an edge, let combinational outputs settle.
  task automatic set_in(input logic r0, input logic l0, input logic [2:0] a0, input logic [2:0] b0,
                        input logic r1, input logic l1, input logic [2:0] a1, input logic [2:0] b1);
    req0 = r0; lock0 = l0; w0 = a0; j0 = b0;
    req1 = r1; lock1 = l1; w1 = a1; j1 = b1;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req0 = 0; lock0 = 0; w0 = 0; j0 = 0;
    req1 = 0; lock1 = 0; w1 = 0; j1 = 0;
    next();

    // Reset state: grants and address forced low even with a request present.
    set_in(1, 1, 3, 5, 1, 0, 4, 6);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_W", W, 0);
    check("rst_busy", busy_cnt, 0);
    check("rst_rvalid0", rvalid0, 0);

    // 1: single lookup by engine 0, cost routed back next cycle.
    do_reset();
    set_in(1, 0, 3, 5, 0, 0, 0, 0);
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    check("t1_W", W, 3);
    check("t1_J", J, 5);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata0", rdata0, 42);
    check("t1_rvalid1", rvalid1, 0);
    check("t1_rdata1", rdata1, 0);
    check("t1_busy", busy_cnt, 0);

    // 2: both single-beat every cycle -> alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 0, 1, 2, 1, 0, 4, 6);
      check("t2_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
      check("t2_gnt1", gnt1, (k % 2 == 1) ? 1 : 0);
      if (k == 1) begin
        check("t2_rvalid0", rvalid0, 1);
        check("t2_rdata0", rdata0, 28);
        check("t2_rvalid1", rvalid1, 0);
      end
      if (k == 2) begin
        check("t2_rvalid1", rvalid1, 1);
        check("t2_rdata1", rdata1, 95);
        check("t2_rdata0", rdata0, 0);
      end
      next();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_busy", busy_cnt, 4);

    // 3: engine 0 burst of 8 with engine 1 waiting.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      set_in(1, (k < 8) ? 1'b1 : 1'b0, 3'(k - 1), 2, 1, 0, 7, 7);
      check("t3_gnt0", gnt0, 1);
      check("t3_gnt1", gnt1, 0);
      next();
    end
    set_in(0, 0, 0, 0, 1, 0, 7, 7);
    check("t3_c9_gnt1", gnt1, 1);
    check("t3_c9_W", W, 7);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_busy", busy_cnt, 8);

    // 4: engine 1 lock stuck high, forced release after 8 beats.
    do_reset();
    set_in(0, 0, 2, 2, 1, 1, 5, 5);
    check("t4_c1_gnt1", gnt1, 1);
    next();
    for (int k = 2; k <= 8; k++) begin
      set_in(1, 0, 2, 2, 1, 1, 5, 5);
      check("t4_gnt1", gnt1, 1);
      check("t4_gnt0", gnt0, 0);
      next();
    end
    set_in(1, 0, 2, 2, 1, 1, 5, 5);
    check("t4_c9_gnt0", gnt0, 1);
    check("t4_c9_gnt1", gnt1, 0);
    next();
    set_in(1, 0, 2, 2, 1, 1, 5, 5);
    check("t4_c10_gnt1", gnt1, 1);
    check("t4_c10_gnt0", gnt0, 0);
    next();

    // 5: bubble inside an engine 0 burst keeps ownership.
    do_reset();
    set_in(1, 1, 1, 1, 0, 0, 0, 0);
    check("t5_c1_gnt0", gnt0, 1);
    next();
    set_in(0, 1, 1, 1, 1, 0, 6, 6);
    check("t5_bub_gnt0", gnt0, 0);
    check("t5_bub_gnt1", gnt1, 0);
    check("t5_bub_W", W, 0);
    next();
    set_in(1, 0, 1, 1, 1, 0, 6, 6);
    check("t5_c3_gnt0", gnt0, 1);
    check("t5_c3_gnt1", gnt1, 0);
    next();
    set_in(0, 0, 0, 0, 1, 0, 6, 6);
    check("t5_c4_gnt1", gnt1, 1);
    next();

    // 6: reset mid-burst with a response in flight.
    do_reset();
    set_in(1, 1, 3, 5, 0, 0, 0, 0);
    check("t6_gnt0", gnt0, 1);
    next();
    rst = 1'b1;
    #1;
    check("t6_rvalid0", rvalid0, 0);
    check("t6_rdata0", rdata0, 0);
    check("t6_rst_gnt0", gnt0, 0);
    check("t6_rst_gnt1", gnt1, 0);
    check("t6_rst_W", W, 0);
    next();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 1, 0, 2, 3);
    check("t6_after_gnt1", gnt1, 1);
    check("t6_after_gnt0", gnt0, 0);
    check("t6_after_rvalid0", rvalid0, 0);
    next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
`default_nettype wire
